exe_ctrl_seq: RTL and testbench

Parametrised execute-stage control unit: decodes ALUOp/funct into the ALU control code and jr flag, and additionally sequences multi-cycle multiply/divide operations via a latency counter and a pipeline stall. It sits between the main decoder and the ALU/MDU in the EX stage and replaces the purely combinational ALU control. It also provides illegal-encoding detection and a synchronous flush.

---
 rtl/exe_ctrl_pkg.sv | 58 +++++
 rtl/exe_ctrl_seq_lat_cnt.sv | 31 +++
 rtl/exe_ctrl_seq.sv | 173 +++++++++++++++++
 tb/tb_exe_ctrl_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_ctrl_pkg.sv
// exe_ctrl_pkg: shared encodings for the EX-stage control unit.
// ALUOp classes, funct fields, ALU control codes, MDU op codes, FSM states.
package exe_ctrl_pkg;

  // ALUOp classes from the main decoder
  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_C1    = 3'b001;
  localparam logic [2:0] ALUOP_C2    = 3'b010;
  localparam logic [2:0] ALUOP_C3    = 3'b011;
  localparam logic [2:0] ALUOP_RSVD  = 3'b100;
  localparam logic [2:0] ALUOP_C5    = 3'b101;
  localparam logic [2:0] ALUOP_C6    = 3'b110;
  localparam logic [2:0] ALUOP_C7    = 3'b111;

  // R-type funct fields
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  // ALU control codes (4-bit, zero-extended at the output)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MDU  = 4'b0100;
  localparam logic [3:0] ALU_C5   = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_C8   = 4'b1000;
  localparam logic [3:0] ALU_CA   = 4'b1010;
  localparam logic [3:0] ALU_CB   = 4'b1011;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_SRAV = 4'b1111;

  // MDU operation codes
  localparam logic [1:0] MDU_MUL = 2'b00;
  localparam logic [1:0] MDU_DIV = 2'b10;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Bits needed to hold max_lat-1 (at least one bit)
  function automatic int cnt_width(input int max_lat);
    return (max_lat > 1) ? $clog2(max_lat) : 1;
  endfunction

endpackage

// File: rtl/exe_ctrl_seq_lat_cnt.sv
// lat_cnt: loadable down-counter that flags when it holds the value 1.
module lat_cnt #(
  parameter int W       = 2,
  parameter int RST_VAL = 0,
  parameter int DEC     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  // Counter register: clear has priority over load, load over decrement
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= W'(RST_VAL);
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - W'(DEC);
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/exe_ctrl_seq.sv
// exe_ctrl_seq: EX-stage ALU control decode plus multi-cycle MDU sequencer.
// Optional divide support is enabled by defining EXE_CTRL_DIV_EN.
module exe_ctrl_seq
  import exe_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              jr_o,
  output logic              illegal_o,
  output logic              stall_o,
  output logic              mdu_start_o,
  output logic [1:0]        mdu_op_o,
  output logic              mdu_sel_o
);

  if (CTRL_W < 4 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
    $error("exe_ctrl_seq: CTRL_W must be >= 4, MUL_LAT and DIV_LAT >= 1");
  end

`ifdef EXE_CTRL_DIV_EN
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
`else
  localparam int MAX_LAT = MUL_LAT;
`endif
  localparam int CNT_W = cnt_width(MAX_LAT);

  logic [3:0]       code;
  logic             bad;
  logic             is_mul;
  logic             is_div;
  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             start;
  logic             cnt_load, cnt_dec, cnt_last;
  logic             multi;
  logic [CNT_W-1:0] load_val;
  int               lat_m1;

  // Combinational decode of ALUOp/funct; every path assigns every flag
  always_comb begin
    code   = ALU_AND;
    jr_o   = 1'b0;
    bad    = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (ALUOp_i)
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADDU: code = ALU_ADD;
          FUNCT_SUBU: code = ALU_SUB;
          FUNCT_AND:  code = ALU_AND;
          FUNCT_OR:   code = ALU_OR;
          FUNCT_SLT:  code = ALU_SLT;
          FUNCT_SRA:  code = ALU_SRA;
          FUNCT_SRAV: code = ALU_SRAV;
          FUNCT_SLL:  code = ALU_SLL;
          FUNCT_MULT: begin
            code   = ALU_MDU;
            is_mul = 1'b1;
          end
          FUNCT_JR: begin
            code = ALU_AND;
            jr_o = 1'b1;
          end
`ifdef EXE_CTRL_DIV_EN
          FUNCT_DIV, FUNCT_DIVU: begin
            code   = ALU_MDU;
            is_div = 1'b1;
          end
`endif
          default: bad = 1'b1;
        endcase
      end
      ALUOP_C1:   code = ALU_ADD;
      ALUOP_C2:   code = ALU_C5;
      ALUOP_C3:   code = ALU_CB;
      ALUOP_C5:   code = ALU_C8;
      ALUOP_C6:   code = ALU_CA;
      ALUOP_C7:   code = ALU_OR;
      ALUOP_RSVD: bad  = 1'b1;
      default:    bad  = 1'b1;
    endcase
  end

  assign ALUCtrl_o = CTRL_W'(code);
  assign illegal_o = valid_i & bad;

  // Latency selection for the op being issued
  always_comb begin
`ifdef EXE_CTRL_DIV_EN
    lat_m1 = is_div ? (DIV_LAT - 1) : (MUL_LAT - 1);
`else
    lat_m1 = MUL_LAT - 1;
`endif
    load_val = CNT_W'(lat_m1);
    multi    = (lat_m1 != 0);
    op_d     = is_div ? MDU_DIV : MDU_MUL;
  end

  // Sequencer next state and stall/start/select; rst and flush squash all pulses
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    stall_o     = 1'b0;
    mdu_sel_o   = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    if (rst_i || flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i && (is_mul || is_div)) begin
            start    = 1'b1;
            stall_o  = 1'b1;
            cnt_load = 1'b1;
            state_d  = multi ? ST_BUSY : ST_DONE;
          end
        end
        ST_BUSY: begin
          stall_o = 1'b1;
          cnt_dec = 1'b1;
          if (cnt_last) state_d = ST_DONE;
        end
        ST_DONE: begin
          mdu_sel_o = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign mdu_start_o = start;
  // The registered op covers BUSY/DONE; the start cycle shows the decoded op
  assign mdu_op_o    = (state_q == ST_IDLE) ? (start ? op_d : MDU_MUL) : op_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // MDU op captured at start and held until the operation retires
  always_ff @(posedge clk_i) begin
    if (rst_i)      op_q <= MDU_MUL;
    else if (start) op_q <= op_d;
  end

  lat_cnt #(
    .W       (CNT_W),
    .RST_VAL (0),
    .DEC     (1)
  ) u_lat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .load_i     (cnt_load),
    .load_val_i (load_val),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

endmodule

// File: tb/tb_exe_ctrl_seq.sv
// Directed bench for exe_ctrl_seq: decode sweep, illegal cases, mul sequencing
// (latency 4 and 1), flush/reset abort and the divide option.
module tb_exe_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst, valid, valid1, flush;
  logic [5:0] funct;
  logic [2:0] aluop;

  logic [3:0] ctrl, ctrl1;
  logic       jr, jr1, ill, ill1, stall, stall1, start, start1, sel, sel1;
  logic [1:0] op, op1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_ctrl_seq #(.CTRL_W(4), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
    .funct_i(funct), .ALUOp_i(aluop), .ALUCtrl_o(ctrl), .jr_o(jr),
    .illegal_o(ill), .stall_o(stall), .mdu_start_o(start),
    .mdu_op_o(op), .mdu_sel_o(sel)
  );

  exe_ctrl_seq #(.CTRL_W(4), .MUL_LAT(1), .DIV_LAT(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1), .flush_i(flush),
    .funct_i(funct), .ALUOp_i(aluop), .ALUCtrl_o(ctrl1), .jr_o(jr1),
    .illegal_o(ill1), .stall_o(stall1), .mdu_start_o(start1),
    .mdu_op_o(op1), .mdu_sel_o(sel1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] a;
    logic [5:0] f;
    logic [3:0] c;
    logic       j;
  } dvec_t;

  dvec_t dv[15];

  initial begin
    dv[0]  = '{3'b000, 6'b100001, 4'b0010, 1'b0};
    dv[1]  = '{3'b000, 6'b100011, 4'b0110, 1'b0};
    dv[2]  = '{3'b000, 6'b100100, 4'b0000, 1'b0};
    dv[3]  = '{3'b000, 6'b100101, 4'b0001, 1'b0};
    dv[4]  = '{3'b000, 6'b101010, 4'b0111, 1'b0};
    dv[5]  = '{3'b000, 6'b000011, 4'b1110, 1'b0};
    dv[6]  = '{3'b000, 6'b000111, 4'b1111, 1'b0};
    dv[7]  = '{3'b000, 6'b000000, 4'b1101, 1'b0};
    dv[8]  = '{3'b000, 6'b001000, 4'b0000, 1'b1};
    dv[9]  = '{3'b001, 6'b000000, 4'b0010, 1'b0};
    dv[10] = '{3'b010, 6'b000000, 4'b0101, 1'b0};
    dv[11] = '{3'b011, 6'b000000, 4'b1011, 1'b0};
    dv[12] = '{3'b101, 6'b000000, 4'b1000, 1'b0};
    dv[13] = '{3'b110, 6'b000000, 4'b1010, 1'b0};
    dv[14] = '{3'b111, 6'b000000, 4'b0001, 1'b0};

    rst = 1'b1; valid = 1'b0; valid1 = 1'b0; flush = 1'b0;
    funct = 6'b0; aluop = 3'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_sel",   sel,   1'b0);
    chk("rst_op",    op,    2'b00);

    // Decode sweep with valid instruction
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      valid = 1'b1; aluop = dv[i].a; funct = dv[i].f;
      @(negedge clk);
      chk($sformatf("dec_ctrl_%0d", i), ctrl, dv[i].c);
      chk($sformatf("dec_jr_%0d", i), jr, dv[i].j);
      chk($sformatf("dec_ill_%0d", i), ill, 1'b0);
      chk($sformatf("dec_stall_%0d", i), stall, 1'b0);
    end

    // Illegal encodings
    next_cycle();
    aluop = 3'b000; funct = 6'b111111; valid = 1'b1;
    @(negedge clk);
    chk("ill_rt_ctrl", ctrl, 4'b0000);
    chk("ill_rt_ill", ill, 1'b1);
    chk("ill_rt_stall", stall, 1'b0);
    next_cycle();
    aluop = 3'b100; funct = 6'b000000;
    @(negedge clk);
    chk("ill_100_ctrl", ctrl, 4'b0000);
    chk("ill_100_ill", ill, 1'b1);
    chk("ill_100_stall", stall, 1'b0);
    next_cycle();
    valid = 1'b0;
    @(negedge clk);
    chk("ill_novalid", ill, 1'b0);

    // Mul, latency 4: issue at cycle 0, held in EX while stalled
    next_cycle();
    aluop = 3'b000; funct = 6'b011000; valid = 1'b1;
    @(negedge clk);
    chk("mul_c0_ctrl",  ctrl,  4'b0100);
    chk("mul_c0_start", start, 1'b1);
    chk("mul_c0_stall", stall, 1'b1);
    chk("mul_c0_op",    op,    2'b00);
    chk("mul_c0_sel",   sel,   1'b0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("mul_c%0d_stall", c), stall, 1'b1);
      chk($sformatf("mul_c%0d_start", c), start, 1'b0);
      chk($sformatf("mul_c%0d_sel", c), sel, 1'b0);
    end
    next_cycle();
    @(negedge clk);
    chk("mul_c4_stall", stall, 1'b0);
    chk("mul_c4_sel",   sel,   1'b1);
    chk("mul_c4_start", start, 1'b0);

    // Back-to-back mul starts at cycle 5
    next_cycle();
    @(negedge clk);
    chk("b2b_c5_start", start, 1'b1);
    chk("b2b_c5_stall", stall, 1'b1);
    chk("b2b_c5_sel",   sel,   1'b0);
    next_cycle();
    @(negedge clk);
    chk("b2b_c6_stall", stall, 1'b1);

    // Flush at cycle 2 of that mul
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", stall, 1'b0);
    chk("fl_start", start, 1'b0);
    chk("fl_sel",   sel,   1'b0);
    next_cycle();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("fl_n1_stall", stall, 1'b0);
    chk("fl_n1_sel",   sel,   1'b0);
    next_cycle();
    @(negedge clk);
    chk("fl_n2_sel",   sel,   1'b0);
    chk("fl_n2_stall", stall, 1'b0);

    // Reset at cycle 2 of a mul
    next_cycle();
    valid = 1'b1;
    @(negedge clk);
    chk("rs_c0_start", start, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("rs_c1_stall", stall, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rs_c2_stall", stall, 1'b0);
    chk("rs_c2_start", start, 1'b0);
    next_cycle();
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("rs_n1_stall", stall, 1'b0);
    chk("rs_n1_sel",   sel,   1'b0);
    chk("rs_n1_op",    op,    2'b00);
    next_cycle();
    @(negedge clk);
    chk("rs_n2_sel", sel, 1'b0);

    // Mul, latency 1 (second instance)
    next_cycle();
    valid1 = 1'b1;
    @(negedge clk);
    chk("l1_c0_start", start1, 1'b1);
    chk("l1_c0_stall", stall1, 1'b1);
    chk("l1_c0_sel",   sel1,   1'b0);
    next_cycle();
    @(negedge clk);
    chk("l1_c1_stall", stall1, 1'b0);
    chk("l1_c1_sel",   sel1,   1'b1);
    chk("l1_c1_start", start1, 1'b0);
    next_cycle();
    valid1 = 1'b0;
    @(negedge clk);
    chk("l1_c2_sel",   sel1,   1'b0);
    chk("l1_c2_stall", stall1, 1'b0);

    // Divide
    next_cycle();
    aluop = 3'b000; funct = 6'b011010; valid = 1'b1;
    @(negedge clk);
`ifdef EXE_CTRL_DIV_EN
    chk("div_c0_start", start, 1'b1);
    chk("div_c0_op",    op,    2'b10);
    chk("div_c0_ctrl",  ctrl,  4'b0100);
    chk("div_c0_ill",   ill,   1'b0);
    for (int c = 1; c <= 31; c++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("div_c%0d_stall", c), stall, 1'b1);
      chk($sformatf("div_c%0d_op", c), op, 2'b10);
    end
    next_cycle();
    @(negedge clk);
    chk("div_c32_stall", stall, 1'b0);
    chk("div_c32_sel",   sel,   1'b1);
    chk("div_c32_op",    op,    2'b10);
    next_cycle();
    valid = 1'b0;
    @(negedge clk);
    chk("div_c33_sel", sel, 1'b0);
    chk("div_c33_op",  op,  2'b00);
`else
    chk("div_ill",   ill,   1'b1);
    chk("div_stall", stall, 1'b0);
    chk("div_start", start, 1'b0);
    chk("div_ctrl",  ctrl,  4'b0000);
    next_cycle();
    funct = 6'b011011;
    @(negedge clk);
    chk("divu_ill",   ill,   1'b1);
    chk("divu_stall", stall, 1'b0);
    next_cycle();
    valid = 1'b0;
    @(negedge clk);
    chk("div_after_sel", sel, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
